jam_cost_table: RTL and testbench

- Upstream stage of the JAM job-assignment engine.
- Accepts the 8x8 worker/job cost matrix as a serial valid/ready stream and stores it in a register file.
- Serves JAM's same-cycle Cost lookup on its W/J indices.
- Holds JAM in reset until a complete, well-framed matrix is loaded, and publishes a lower bound on total cost (the sum of the row minima).

---
 rtl/jam_cost_table_if.sv | 13 +
 rtl/jam_cost_table.sv | 126 ++++++++++++
 tb/tb_jam_cost_table.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_table_if.sv
// Cost-matrix beat stream into the JAM cost table.
// The master drives beats; the slave answers with in_ready.
interface jam_cost_table_if #(
   parameter int COST_W = 7
);
   logic              in_valid;
   logic              in_ready;
   logic [COST_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/jam_cost_table.sv
// Loads the JAM worker/job cost matrix from a beat stream, serves zero-latency lookups,
// holds JAM in reset until a well-framed matrix is present, and publishes the row-minimum bound.
module jam_cost_table #(
   parameter int N_IDX  = 8,
   parameter int IDX_W  = 3,
   parameter int COST_W = 7,
   parameter int SUM_W  = 10
) (
   input  logic               CLK,
   input  logic               RST,
   jam_cost_table_if.slave    cost_stream,
   input  logic               reload,
   input  logic [IDX_W-1:0]   W,
   input  logic [IDX_W-1:0]   J,
   output logic [COST_W-1:0]  Cost,
   output logic               jam_rst,
   output logic               table_valid,
   output logic [SUM_W-1:0]   min_bound,
   output logic               frame_err
);
   localparam int ADDR_W = 2 * IDX_W;
   localparam logic [IDX_W-1:0]  LAST_COL  = IDX_W'(N_IDX - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IDX * N_IDX - 1);

   typedef enum logic {LOAD, SERVE} state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic [COST_W-1:0]  row_min_reg, row_min_next;
   logic [SUM_W-1:0]   bound_acc_reg, bound_acc_next;
   logic [SUM_W-1:0]   min_bound_reg, min_bound_next;
   logic               frame_err_reg, frame_err_next;
   logic               write_en;
   logic [COST_W-1:0]  cur_min;
   logic [SUM_W-1:0]   row_sum;
   logic [COST_W-1:0]  cost_mem [N_IDX*N_IDX];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= LOAD;
         addr_reg      <= '0;
         row_min_reg   <= '0;
         bound_acc_reg <= '0;
         min_bound_reg <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         row_min_reg   <= row_min_next;
         bound_acc_reg <= bound_acc_next;
         min_bound_reg <= min_bound_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      row_min_next   = row_min_reg;
      bound_acc_next = bound_acc_reg;
      min_bound_next = min_bound_reg;
      frame_err_next = frame_err_reg;
      write_en       = 1'b0;

      // Running minimum of the current row, including the beat on the bus.
      if (addr_reg[IDX_W-1:0] == '0)
         cur_min = cost_stream.in_data;
      else if (cost_stream.in_data < row_min_reg)
         cur_min = cost_stream.in_data;
      else
         cur_min = row_min_reg;

      // The first row starts the sum fresh so stale accumulator contents never leak in.
      if (addr_reg[ADDR_W-1:IDX_W] == '0)
         row_sum = {{(SUM_W-COST_W){1'b0}}, cur_min};
      else
         row_sum = bound_acc_reg + {{(SUM_W-COST_W){1'b0}}, cur_min};

      case (state_reg)
         LOAD: begin
            if (reload) begin
               addr_next      = '0;
               bound_acc_next = '0;
            end else if (cost_stream.in_valid) begin
               write_en     = 1'b1;
               row_min_next = cur_min;
               if (addr_reg[IDX_W-1:0] == LAST_COL)
                  bound_acc_next = row_sum;
               if (cost_stream.in_last != (addr_reg == LAST_ADDR)) begin
                  frame_err_next = 1'b1;
                  addr_next      = '0;
                  bound_acc_next = '0;
               end else if (addr_reg == LAST_ADDR) begin
                  min_bound_next = row_sum;
                  addr_next      = '0;
                  state_next     = SERVE;
               end else begin
                  addr_next = addr_reg + ADDR_W'(1);
               end
            end
         end
         SERVE: begin
            if (reload) begin
               state_next     = LOAD;
               addr_next      = '0;
               bound_acc_next = '0;
               min_bound_next = '0;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // Table storage carries no reset; contents are only meaningful in SERVE.
   always_ff @(posedge CLK) begin
      if (write_en)
         cost_mem[addr_reg] <= cost_stream.in_data;
   end

   assign cost_stream.in_ready = (state_reg == LOAD);
   assign table_valid          = (state_reg == SERVE);
   assign jam_rst              = RST | (state_reg != SERVE);
   assign Cost                 = (state_reg == SERVE) ? cost_mem[{W, J}] : '0;
   assign min_bound            = min_bound_reg;
   assign frame_err            = frame_err_reg;
endmodule

// File: tb/tb_jam_cost_table.sv
// Randomised bench for jam_cost_table: a scoreboard of expected bounds is drained by a
// monitor on each table_valid rise, while the stimulus side checks lookups and framing.
module tb_jam_cost_table;
   logic       CLK = 1'b0;
   logic       RST;
   logic       reload;
   logic [2:0] W, J;
   logic [6:0] Cost;
   logic       jam_rst, table_valid, frame_err;
   logic [9:0] min_bound;

   always #5 CLK = ~CLK;

   jam_cost_table_if #(.COST_W(7)) cs ();

   jam_cost_table dut (
      .CLK         (CLK),
      .RST         (RST),
      .cost_stream (cs),
      .reload      (reload),
      .W           (W),
      .J           (J),
      .Cost        (Cost),
      .jam_rst     (jam_rst),
      .table_valid (table_valid),
      .min_bound   (min_bound),
      .frame_err   (frame_err)
   );

   typedef struct {int bound; int err;} exp_t;
   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [6:0] frame   [64];
   logic [6:0] ref_tbl [64];
   int         exp_err = 0;
   int         checks = 0;
   int         failures = 0;
   logic       tv_prev = 1'b0;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Lower bound = sum over workers of the smallest cost in that worker's row.
   function automatic int bound_of(logic [6:0] f [64]);
      int s = 0;
      for (int w = 0; w < 8; w++) begin
         int m = f[w*8];
         for (int j = 1; j < 8; j++)
            if (f[w*8+j] < m) m = f[w*8+j];
         s += m;
      end
      return s;
   endfunction

   // Monitor: every new SERVE entry must match the oldest expected matrix.
   always @(negedge CLK) begin
      if (table_valid && !tv_prev) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_serve", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("min_bound", int'(min_bound), mon_e.bound);
            chk("frame_err_at_serve", int'(frame_err), mon_e.err);
         end
      end
      tv_prev = table_valid;
   end

   task automatic idle_cycle(bit chk_ready);
      @(negedge CLK);
      cs.in_valid = 1'b0;
      cs.in_last  = 1'b0;
      #1;
      if (chk_ready) chk("in_ready_gap", int'(cs.in_ready), 1);
   endtask

   task automatic send_beat(logic [6:0] d, logic last);
      @(negedge CLK);
      cs.in_valid = 1'b1;
      cs.in_data  = d;
      cs.in_last  = last;
   endtask

   // gap_mode 0: back-to-back, 1: one idle between beats, 2: random idles.
   task automatic send_frame(int n, int last_pos, int gap_mode);
      for (int k = 0; k < n; k++) begin
         if (k > 0 && gap_mode == 1) idle_cycle(1'b1);
         if (k > 0 && gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
         send_beat(frame[k], k == last_pos);
      end
   endtask

   task automatic expect_frame();
      ref_tbl = frame;
      exp_q.push_back('{bound_of(frame), exp_err});
   endtask

   task automatic check_lookups(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         W = 3'($urandom_range(0, 7));
         J = 3'($urandom_range(0, 7));
         #1 chk("cost_lookup", int'(Cost), int'(ref_tbl[{W, J}]));
      end
   endtask

   task automatic lookup_at(logic [2:0] w, logic [2:0] j, int req);
      @(negedge CLK);
      W = w;
      J = j;
      #1 chk("cost_at", int'(Cost), req);
   endtask

   // Reload from SERVE, optionally with a beat held on the bus.
   task automatic pulse_reload(bit with_valid);
      @(negedge CLK);
      reload      = 1'b1;
      cs.in_valid = with_valid;
      cs.in_data  = 7'd99;
      cs.in_last  = 1'b0;
      #1 chk("in_ready_reload", int'(cs.in_ready), 0);
      @(negedge CLK);
      reload      = 1'b0;
      cs.in_valid = 1'b0;
      #1;
      chk("tv_after_reload", int'(table_valid), 0);
      chk("jam_rst_after_reload", int'(jam_rst), 1);
      chk("cost_after_reload", int'(Cost), 0);
   endtask

   task automatic fill_const(int v);
      for (int k = 0; k < 64; k++) frame[k] = 7'(v);
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 64; k++) frame[k] = 7'($urandom_range(0, 127));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; reload = 1'b0; W = '0; J = '0;
      cs.in_valid = 1'b0; cs.in_data = '0; cs.in_last = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("jam_rst_in_reset", int'(jam_rst), 1);
      RST = 1'b0;
      @(negedge CLK); #1;
      chk("reset_tv", int'(table_valid), 0);
      chk("reset_jam_rst", int'(jam_rst), 1);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_min_bound", int'(min_bound), 0);
      chk("reset_cost", int'(Cost), 0);
      chk("reset_in_ready", int'(cs.in_ready), 1);

      // Ramp frame, no gaps; SERVE exactly one cycle after the last beat.
      for (int k = 0; k < 64; k++) frame[k] = 7'(k);
      expect_frame();
      send_frame(64, 63, 0);
      #1 chk("tv_before_last_edge", int'(table_valid), 0);
      idle_cycle(1'b0);
      chk("tv_latency", int'(table_valid), 1);
      chk("jam_rst_released", int'(jam_rst), 0);
      chk("ramp_min_bound", int'(min_bound), 224);
      lookup_at(3'd2, 3'd5, 21);
      check_lookups(6);

      // Reload from SERVE with in_valid held, then the same frame with alternate gaps.
      pulse_reload(1'b1);
      expect_frame();
      send_frame(64, 63, 1);
      idle_cycle(1'b0);
      check_lookups(6);

      // Early in_last, then a full all-127 frame.
      pulse_reload(1'b0);
      send_frame(11, 10, 0);
      idle_cycle(1'b0);
      chk("early_last_err", int'(frame_err), 1);
      chk("early_last_tv", int'(table_valid), 0);
      exp_err = 1;
      fill_const(127);
      expect_frame();
      send_frame(64, 63, 0);
      idle_cycle(1'b0);
      check_lookups(4);

      // Missing in_last; the following frame must start at table[0][0].
      pulse_reload(1'b0);
      fill_rand();
      send_frame(64, -1, 0);
      idle_cycle(1'b0);
      chk("missing_last_err", int'(frame_err), 1);
      chk("missing_last_tv", int'(table_valid), 0);
      fill_rand();
      expect_frame();
      send_frame(64, 63, 2);
      idle_cycle(1'b0);
      lookup_at(3'd0, 3'd0, int'(frame[0]));
      check_lookups(4);

      // Reload mid-load with a beat presented in the same cycle, then an all-3 frame.
      pulse_reload(1'b0);
      fill_rand();
      send_frame(20, -1, 0);
      @(negedge CLK);
      reload = 1'b1; cs.in_valid = 1'b1; cs.in_data = 7'd5; cs.in_last = 1'b0;
      @(negedge CLK);
      reload = 1'b0; cs.in_valid = 1'b0;
      fill_const(3);
      expect_frame();
      send_frame(64, 63, 0);
      idle_cycle(1'b0);
      chk("all3_min_bound", int'(min_bound), 24);
      check_lookups(3);

      // RST during beat 40 of a load.
      pulse_reload(1'b0);
      fill_rand();
      send_frame(40, -1, 0);
      @(negedge CLK);
      RST = 1'b1; cs.in_valid = 1'b1; cs.in_data = 7'd77;
      #1 chk("jam_rst_comb", int'(jam_rst), 1);
      @(negedge CLK);
      RST = 1'b0; cs.in_valid = 1'b0;
      #1;
      chk("rst_frame_err", int'(frame_err), 0);
      chk("rst_min_bound", int'(min_bound), 0);
      chk("rst_tv", int'(table_valid), 0);
      exp_err = 0;
      fill_rand();
      expect_frame();
      send_frame(64, 63, 2);
      idle_cycle(1'b0);
      check_lookups(6);

      // Random frames with random gaps.
      for (int r = 0; r < 3; r++) begin
         pulse_reload(1'b0);
         fill_rand();
         expect_frame();
         send_frame(64, 63, 2);
         idle_cycle(1'b0);
         check_lookups(5);
      end

      repeat (3) idle_cycle(1'b0);
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
